// File: rtl/modulation_scheduler.sv
// Modulation scheduler: Avalon-MM programmable sequencer of 4-bit modulation selects; optional irq via MOD_SCHED_IRQ_EN.
// Latency: register writes reach out_port on the next edge; readdata is combinational with zero wait states.
// Backpressure: none; the slave always accepts, and SEQ/LEN/DWELL changes apply at the next entry load.
module modulation_scheduler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [3:0]  out_port
`ifdef MOD_SCHED_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_MANUAL  = 3'd1;
    localparam logic [2:0] A_SEQ     = 3'd2;
    localparam logic [2:0] A_LEN     = 3'd3;
    localparam logic [2:0] A_DWELL   = 3'd4;
    localparam logic [2:0] A_STATUS  = 3'd5;
    localparam logic [2:0] A_IRQMASK = 3'd6;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_manual, r_out, w_manual_nxt, w_entry;
    logic [15:0] r_seq;
    logic [1:0]  r_len, r_index, w_load_idx;
    logic [23:0] r_dwell, r_cnt, w_reload;
    logic        r_loop, r_done, w_done_nxt;
    logic        w_wr, w_start, w_stop, w_load, w_set_done, w_clr_done;
    logic        w_unused;

    assign w_wr         = chipselect && !write_n;
    assign w_start      = w_wr && (address == A_CTRL) && writedata[0];
    assign w_stop       = w_wr && (address == A_CTRL) && writedata[1];
    assign w_clr_done   = w_wr && (address == A_STATUS) && writedata[3];
    assign w_manual_nxt = (w_wr && (address == A_MANUAL)) ? writedata[3:0] : r_manual;
    assign w_reload     = (r_dwell == 24'd0) ? 24'd0 : r_dwell - 24'd1;
    assign w_done_nxt   = w_set_done || (r_done && !w_clr_done);
    assign w_unused     = ^writedata[31:24];
    assign out_port     = r_out;

    always_comb begin
        w_entry = r_seq[3:0];
        case (w_load_idx)
            2'd1:    w_entry = r_seq[7:4];
            2'd2:    w_entry = r_seq[11:8];
            2'd3:    w_entry = r_seq[15:12];
            default: w_entry = r_seq[3:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // STOP outranks START; LOOP is sampled only at the wrap point.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_idx  = 2'd0;
        w_set_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start && !w_stop) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                if (w_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_start) begin
                    w_load = 1'b1;
                end else if (r_cnt == 24'd0) begin
                    if (r_index < r_len) begin
                        w_load     = 1'b1;
                        w_load_idx = r_index + 2'd1;
                    end else if (r_loop) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_set_done  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_index <= 2'd0;
            r_cnt   <= 24'd0;
            r_out   <= 4'd0;
        end else if (w_load) begin
            r_index <= w_load_idx;
            r_cnt   <= w_reload;
            r_out   <= w_entry;
        end else if (w_state_nxt == S_IDLE) begin
            r_index <= 2'd0;
            r_cnt   <= 24'd0;
            r_out   <= w_manual_nxt;
        end else begin
            r_cnt   <= r_cnt - 24'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_manual <= 4'd0;
            r_seq    <= 16'd0;
            r_len    <= 2'd0;
            r_dwell  <= 24'd0;
            r_loop   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_manual <= w_manual_nxt;
            r_done   <= w_done_nxt;
            if (w_wr) begin
                case (address)
                    A_CTRL:  r_loop  <= writedata[2];
                    A_SEQ:   r_seq   <= writedata[15:0];
                    A_LEN:   r_len   <= writedata[1:0];
                    A_DWELL: r_dwell <= writedata[23:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef MOD_SCHED_IRQ_EN
    logic r_irqmask, r_irq, w_mask_nxt;
    assign w_mask_nxt = (w_wr && (address == A_IRQMASK)) ? writedata[0] : r_irqmask;
    assign irq        = r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_irqmask <= w_mask_nxt;
            r_irq     <= w_done_nxt && w_mask_nxt;
        end
    end
`endif

    always_comb begin
        readdata = 32'd0;
        case (address)
            A_CTRL:    readdata[2]     = r_loop;
            A_MANUAL:  readdata[3:0]   = r_manual;
            A_SEQ:     readdata[15:0]  = r_seq;
            A_LEN:     readdata[1:0]   = r_len;
            A_DWELL:   readdata[23:0]  = r_dwell;
            A_STATUS:  readdata[7:0]   = {r_out, r_done, r_index, (r_state == S_RUN)};
`ifdef MOD_SCHED_IRQ_EN
            A_IRQMASK: readdata[0]     = r_irqmask;
`endif
            default:   readdata        = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_modulation_scheduler.sv
// Self-checking bench for modulation_scheduler: directed scenarios plus randomized sequences
// compared against expected out_port traces derived from the register settings.
module tb_modulation_scheduler;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    wire  [31:0] readdata;
    wire  [3:0]  out_port;
`ifdef MOD_SCHED_IRQ_EN
    wire         irq;
`endif

    modulation_scheduler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
`ifdef MOD_SCHED_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic       rec = 1'b0;
    logic [3:0] log_q[$];
    logic [3:0] exp_q[$];
    logic [31:0] rd;

    always @(negedge clk) if (rec) log_q.push_back(out_port);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1 chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1 d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic record(input int n);
        log_q.delete();
        rec = 1'b1;
        repeat (n) @(negedge clk);
        #1 rec = 1'b0;
    endtask

    // One full pass of the programmed sequence: each entry held max(DWELL,1) cycles.
    function automatic void add_pass(input logic [15:0] seq, input int len, input int dw);
        int hold = (dw == 0) ? 1 : dw;
        for (int e = 0; e <= len; e++)
            for (int c = 0; c < hold; c++)
                exp_q.push_back(4'((seq >> (4 * e)) & 16'hF));
    endfunction

    task automatic compare_log(input string tag, input int n);
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", tag, i),
                  (i < log_q.size()) ? {28'd0, log_q[i]} : 32'hDEAD,
                  {28'd0, exp_q[i]});
    endtask

    initial begin
        logic [3:0]  man;
        logic [15:0] seq;
        int          len, dw, lp, n;

        repeat (3) @(negedge clk);
        check("rst_out", {28'd0, out_port}, 32'h0);
        bus_rd(3'd5, rd); check("rst_status", rd, 32'h0);
        bus_rd(3'd1, rd); check("rst_manual", rd, 32'h0);
        @(negedge clk) reset_n = 1'b1;

        bus_wr(3'd1, 32'h5);
        check("manual_out", {28'd0, out_port}, 32'h5);
        bus_rd(3'd1, rd); check("manual_rd", rd, 32'h5);

        bus_wr(3'd2, 32'h4321); bus_wr(3'd3, 32'd3); bus_wr(3'd4, 32'd3); bus_wr(3'd0, 32'h0);
        bus_rd(3'd2, rd); check("seq_rd", rd, 32'h4321);
        bus_rd(3'd4, rd); check("dwell_rd", rd, 32'd3);
        bus_wr(3'd0, 32'h1);
        exp_q.delete(); add_pass(16'h4321, 3, 3); exp_q.push_back(4'h5); exp_q.push_back(4'h5);
        record(14); compare_log("seq_once", 14);
        bus_rd(3'd5, rd); check("status_done", rd, 32'h58);
        bus_wr(3'd5, 32'h8);
        bus_rd(3'd5, rd); check("status_clr", rd, 32'h50);

        bus_wr(3'd0, 32'h5);
        bus_rd(3'd0, rd); check("ctrl_loop_rd", rd, 32'h4);
        exp_q.delete(); repeat (3) add_pass(16'h4321, 3, 3);
        record(30); compare_log("seq_loop", 30);
        bus_wr(3'd0, 32'h2);
        check("stop_out", {28'd0, out_port}, 32'h5);
        bus_rd(3'd5, rd); check("stop_status", rd, 32'h50);

        bus_wr(3'd4, 32'd0); bus_wr(3'd3, 32'd1); bus_wr(3'd2, 32'hA9); bus_wr(3'd0, 32'h1);
        exp_q.delete(); exp_q = '{4'h9, 4'hA, 4'h5, 4'h5};
        record(4); compare_log("dwell0", 4);
        bus_wr(3'd5, 32'h8);
        bus_wr(3'd0, 32'h5);
        exp_q.delete(); exp_q = '{4'h9, 4'hA, 4'h9, 4'hA, 4'h9};
        record(5); compare_log("dwell0_loop", 5);
        bus_wr(3'd0, 32'h3);
        check("startstop_out", {28'd0, out_port}, 32'h5);
        bus_rd(3'd5, rd); check("startstop_status", rd, 32'h50);
        bus_wr(3'd0, 32'h3);
        repeat (2) @(negedge clk);
        bus_rd(3'd5, rd); check("startstop_idle", rd, 32'h50);

        bus_wr(3'd4, 32'd4); bus_wr(3'd2, 32'h21); bus_wr(3'd3, 32'd1); bus_wr(3'd0, 32'h1);
        exp_q.delete(); add_pass(16'h1, 0, 4); add_pass(16'h2, 0, 10);
        exp_q.push_back(4'h5); exp_q.push_back(4'h5);
        fork
            record(16);
            bus_wr(3'd4, 32'd10);
        join
        compare_log("dwell_midrun", 16);
        bus_wr(3'd5, 32'h8);

        bus_wr(3'd4, 32'd2); bus_wr(3'd0, 32'h5);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1 check("arst_out", {28'd0, out_port}, 32'h0);
        bus_rd(3'd5, rd); check("arst_status", rd, 32'h0);
        bus_rd(3'd0, rd); check("arst_ctrl", rd, 32'h0);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(negedge clk);
        bus_rd(3'd5, rd); check("post_arst_status", rd, 32'h0);

        bus_wr(3'd7, 32'hFFFF_FFFF);
        bus_rd(3'd7, rd); check("addr7_rd", rd, 32'h0);
`ifdef MOD_SCHED_IRQ_EN
        bus_wr(3'd6, 32'h1);
        bus_rd(3'd6, rd); check("irqmask_rd", rd, 32'h1);
        check("irq_idle", {31'd0, irq}, 32'h0);
        bus_wr(3'd4, 32'd1); bus_wr(3'd3, 32'd0); bus_wr(3'd2, 32'h7); bus_wr(3'd0, 32'h1);
        repeat (2) @(negedge clk);
        check("irq_set", {31'd0, irq}, 32'h1);
        bus_wr(3'd5, 32'h8);
        check("irq_clr", {31'd0, irq}, 32'h0);
        bus_wr(3'd6, 32'h0);
`else
        bus_wr(3'd6, 32'hFFFF_FFFF);
        bus_rd(3'd6, rd); check("addr6_rd", rd, 32'h0);
`endif

        for (int it = 0; it < 16; it++) begin
            man = 4'($urandom_range(0, 15));
            seq = 16'($urandom);
            len = $urandom_range(0, 3);
            dw  = $urandom_range(0, 5);
            lp  = $urandom_range(0, 1);
            bus_wr(3'd1, {28'd0, man}); bus_wr(3'd2, {16'd0, seq});
            bus_wr(3'd3, 32'(len)); bus_wr(3'd4, 32'(dw));
            bus_wr(3'd0, {29'd0, lp[0], 2'b01});
            exp_q.delete();
            if (lp == 0) begin
                add_pass(seq, len, dw);
                exp_q.push_back(man); exp_q.push_back(man);
                n = exp_q.size();
                record(n); compare_log($sformatf("rnd%0d", it), n);
                bus_rd(3'd5, rd); check($sformatf("rnd%0d_status", it), rd, {24'd0, man, 4'h8});
                bus_wr(3'd5, 32'h8);
            end else begin
                n = $urandom_range(3, 30);
                while (exp_q.size() < n) add_pass(seq, len, dw);
                record(n); compare_log($sformatf("rndloop%0d", it), n);
                bus_wr(3'd0, 32'h2);
                check($sformatf("rndloop%0d_out", it), {28'd0, out_port}, {28'd0, man});
                bus_rd(3'd5, rd); check($sformatf("rndloop%0d_status", it), rd, {24'd0, man, 4'h0});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/modulation_scheduler.md
MODULATION_SCHEDULER -- requirements
Module: modulation_scheduler

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port address, input, 3 bits: Avalon-MM slave word address.
REQ-004 SHALL have port chipselect, input, 1 bit: Avalon-MM slave select.
REQ-005 SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-006 SHALL have port writedata, input, 32 bits: write data.
REQ-007 SHALL have port readdata, output, 32 bits: read data; combinational, zero wait states; unused bits 0.
REQ-008 SHALL have port out_port, output, 4 bits: registered modulation select driven to the modulator datapath.
REQ-009 SHALL have port irq, output, 1 bit, present only when MOD_SCHED_IRQ_EN is defined.

Function
REQ-010 SHALL decode these registers: 0 CTRL, 1 MANUAL, 2 SEQ, 3 LEN, 4 DWELL, 5 STATUS, 6 IRQMASK.
- CTRL: write bit0 START strobe, bit1 STOP strobe, bit2 LOOP stored; read returns LOOP in bit2.
- MANUAL[3:0], SEQ[15:0] (entry n in bits 4n+3:4n), LEN[1:0] (entries-1), DWELL[23:0]: read/write.
- Unlisted addresses: reads return 0, writes are ignored.
REQ-011 SHALL implement FSM states IDLE and RUN; write = chipselect && !write_n.
REQ-012 In IDLE, out_port SHALL equal MANUAL, updating the cycle after a MANUAL write.
REQ-013 START in IDLE SHALL, on the next edge: enter RUN, index=0, out_port=SEQ entry 0, dwell counter=max(DWELL,1)-1.
REQ-014 In RUN the counter SHALL decrement each cycle; at 0 with index<LEN it SHALL advance index, load out_port=SEQ[index+1] and reload the counter.
REQ-015 At counter 0 with index==LEN: LOOP=1 SHALL wrap to index 0 and reload; LOOP=0 SHALL go to IDLE, set out_port=MANUAL and set STATUS.done.
REQ-016 Each entry SHALL be held exactly max(DWELL,1) cycles; DWELL=0 SHALL behave as 1.
REQ-017 SEQ, LEN and DWELL writes during RUN SHALL take effect at the next entry load only.
REQ-018 STOP in RUN SHALL go to IDLE next edge with out_port=MANUAL; done SHALL not be set.
REQ-019 START in RUN SHALL restart from entry 0.
REQ-020 START and STOP in the same write: STOP SHALL win.
REQ-021 A LOOP clear during RUN SHALL end the sequence at the next wrap point.
REQ-022 STATUS read SHALL return bit0 busy (RUN), bits[2:1] index, bit3 done (sticky), bits[7:4] out_port.
REQ-023 Writing STATUS with bit3=1 SHALL clear done; if done sets in the same cycle, set wins.

Reset
REQ-024 reset_n low SHALL asynchronously force: IDLE; index, counter and out_port to 0; MANUAL, SEQ, LEN, DWELL, LOOP, done, IRQMASK to 0; irq to 0.
REQ-025 Reset asserted mid-RUN SHALL abort the sequence with no done indication.

Configuration
REQ-026 With MOD_SCHED_IRQ_EN defined:
- IRQMASK bit0 SHALL be read/write.
- irq SHALL be registered and equal done AND IRQMASK[0].
REQ-027 Without MOD_SCHED_IRQ_EN:
- irq port and the IRQMASK register SHALL be absent.
- Address 6 SHALL read 0.

Verification
REQ-028 Reset then MANUAL=0x5 -> out_port=0x0 during reset, 0x5 one cycle after the write.
REQ-029 SEQ=0x4321, LEN=3, DWELL=3, LOOP=0, START -> out_port 1,2,3,4 for 3 cycles each, then 0x5; STATUS=0x58 afterward.
REQ-030 As REQ-029 with LOOP=1 -> sequence 1,2,3,4,1,... repeats; STOP mid-entry -> out_port=0x5 next cycle, busy=0, done=0.
REQ-031 DWELL=0, LEN=1, SEQ=0x00A9 -> out_port 9 then A, one cycle each, then MANUAL; CTRL write 0x3 in RUN -> stops.
REQ-032 DWELL write 10 during entry 0 of a DWELL=4 run -> entry 0 lasts 4 cycles, entry 1 lasts 10 cycles.
REQ-033 IRQ build, IRQMASK=1, sequence completes -> irq=1; STATUS write 0x8 -> irq=0 next cycle.
